ifetch_prefetch: RTL
====================

# ifetch_prefetch

Instruction fetch and prefetch unit that sits directly upstream of the single-cycle MIPS core. It reads the byte-wide instruction memory one byte per cycle and assembles big-endian 32-bit instruction words. Each word is stored with its PC in a small FIFO and presented to the core over a valid/ready interface. A redirect input (taken branch, j/jal/jr target) flushes all prefetched state and restarts fetch at the new PC.

## Interface
Parameters:
- DEPTH, 4, FIFO capacity in instruction words (power of two, ≥2)
- MEM_AW, 5, instruction-memory byte-address width (32-byte memory)

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- redirect  in  1  flush and restart fetch this cycle
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored (forced 00)
- mem_rd  out  1  byte read request
- mem_addr  out  MEM_AW  byte address, fpc[MEM_AW-1:0] + byte index, modulo 2^MEM_AW
- mem_rdata  in  8  read data, valid the cycle after the request
- inst_valid  out  1  inst/inst_pc hold a fetched word
- inst  out  32  instruction word, first byte in [31:24]
- inst_pc  out  32  byte address of inst
- inst_ready  in  1  core consumes the head word when high with inst_valid

## Operation
- State: fpc (32-bit fetch PC), issue index k (0..3), capture index c (0..3), 24-bit assembly register, rd_pend flag, FIFO of {pc, inst}, occupancy count, words_in_flight (0..2).
- FSM states:
  - ISSUE: mem_rd=1, mem_addr = fpc+k. k increments each cycle. After k=3, fpc += 4 and k=0.
  - WAIT: mem_rd=0. Entered instead of starting byte 0 of a word when credit fails.
- Credit: byte 0 of a word may be issued only if occupancy + words_in_flight < DEPTH. A pop in the same cycle is not counted. WAIT→ISSUE as soon as credit holds.
- Capture: rd_pend is mem_rd registered. When rd_pend=1, mem_rdata is stored at byte c, and c increments. At c=3 the word {assembly, mem_rdata} is pushed with its pc, and words_in_flight decrements.
- Pop: on inst_valid & inst_ready, the head entry is removed.
- Redirect, from any state:
  - fpc = {redirect_pc[31:2], 2'b00}, k=0, c=0.
  - FIFO emptied; occupancy and words_in_flight set to 0; rd_pend cleared, so the byte returning next cycle is discarded.
  - mem_rd=0 in the redirect cycle; the FSM goes to ISSUE next cycle.
  - Redirect wins over a simultaneous pop or push.
- fpc wraps at 32 bits. mem_addr wraps independently at 2^MEM_AW, so memory aliasing is the memory's behaviour.

## Timing
- Reset values: mem_rd=0, mem_addr=0, inst_valid=0, inst=0, inst_pc=0, fpc=0, FSM=ISSUE, all counters 0. Reset assertion clears everything asynchronously, including mid-word.
- Cycle C0 is the first cycle after reset_n rises. mem_rd=1 with addr 0 in C0..C3; bytes return in C1..C4.
- The word is pushed at the end of C4, and inst_valid=1 in C5 without bypass.
- Steady state with inst_ready=1: one word every 4 cycles, with no bubbles between words.
- After a redirect in cycle R: first request in R+1, inst_valid in R+6 without bypass.
- Full: at most DEPTH words buffered plus in-flight words, never overflowing. mem_rd stays 0 in WAIT.
- Empty: inst_valid=0; inst and inst_pc hold their last values.

## Configuration
- IFETCH_BYPASS_EN defined:
  - When the FIFO is empty and a word completes capture, inst_valid, inst and inst_pc are driven combinationally from {assembly, mem_rdata} in that cycle.
  - If inst_ready=1, the word is consumed without being written to the FIFO.
  - First inst_valid arrives in C4; after a redirect, in R+5.
- IFETCH_BYPASS_EN undefined: all outputs come from FIFO registers, with the latencies given above.

## Test plan
- Sequential fetch: mem[i]=i for i=0..31, inst_ready=1 → inst_valid first in C5 with 0x00010203/pc 0x0; then 0x04050607/pc 0x4 four cycles later.
- Backpressure: inst_ready=0, DEPTH=4 → exactly 4 words buffered (pcs 0,4,8,C). mem_rd stays 0 and no further reads occur. Releasing inst_ready drains the words in order, and fetch resumes at 0x10.
- Redirect mid-word: redirect with redirect_pc=0x12 while byte 2 of the word at 0x8 is issuing → FIFO flushed, stale byte discarded. Next word is 0x10111213/pc 0x10 in R+6.
- Wrap: redirect_pc=0x1C → 0x1C1D1E1F/pc 0x1C, then 0x00010203/pc 0x20 (mem_addr wraps to 0).
- Async reset mid-operation: reset_n=0 between edges during capture → all outputs 0 immediately. After release, fetch restarts at 0 and the first word appears in C5.
- With IFETCH_BYPASS_EN: the sequential-fetch scenario gives its first inst_valid in C4. With inst_ready=1 throughout, FIFO occupancy stays 0.

Source files
------------

// File: rtl/ifetch_prefetch.sv
// ifetch_prefetch
// ---------------------------------------------------------------------------
// Instruction fetch/prefetch unit for the single-cycle MIPS core.
// Reads the byte-wide instruction memory one byte per cycle and assembles
// big-endian 32-bit words. Each word is queued with its PC in a small FIFO and
// offered to the core. A redirect flushes everything and restarts fetch.
//
// Handshake: a word transfers on any rising edge where inst_valid and
// inst_ready are both high. inst_valid never depends on inst_ready. While
// inst_valid is low, inst/inst_pc hold the last word that was presented.
//
// Optional feature: define IFETCH_BYPASS_EN to present a word combinationally
// in the cycle its last byte arrives, if the FIFO is empty.
//
// Ports:
//   clk          clock, rising edge
//   reset_n      asynchronous active-low reset
//   redirect     flush and restart fetch at redirect_pc (bits [1:0] ignored)
//   redirect_pc  new fetch PC
//   mem_rd       byte read request
//   mem_addr     byte address (fetch PC + byte index, modulo 2^MEM_AW)
//   mem_rdata    read data, returned the cycle after the request
//   inst_valid   inst/inst_pc carry a fetched word
//   inst         instruction word, first byte in [31:24]
//   inst_pc      byte address of inst
//   inst_ready   core accepts the head word
//   dbg_state_o  fetch FSM state (0 = ISSUE, 1 = WAIT)
// ---------------------------------------------------------------------------
module ifetch_prefetch #(
  parameter int DEPTH  = 4,
  parameter int MEM_AW = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic              mem_rd,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              inst_valid,
  output logic [31:0]       inst,
  output logic [31:0]       inst_pc,
  input  logic              inst_ready,
  output logic [0:0]        dbg_state_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [0:0] ST_ISSUE = 1'b0;
  localparam logic [0:0] ST_WAIT  = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [31:0]   fpc_q, fpc_d;
  logic [1:0]    k_q, k_d;
  logic [1:0]    c_q, c_d;
  logic [23:0]   asm_q, asm_d;
  logic          rd_pend_q;
  logic [31:0]   cap_pc_q, cap_pc_d;
  logic [1:0]    wif_q, wif_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]   last_inst_q, last_pc_q;
  logic [31:0]   fifo_inst [DEPTH];
  logic [31:0]   fifo_pc   [DEPTH];

  logic          credit, start_word, capture_done, push, pop, fifo_valid;
  logic          byp_show, byp_take;
  logic [31:0]   cap_word;
  logic [AW+1:0] occ_sum;

  // Credit counts words already queued plus words whose bytes are still in
  // flight, so a word is only started when a FIFO slot is guaranteed for it.
  assign occ_sum    = (AW+2)'(count_q) + (AW+2)'(wif_q);
  assign credit     = occ_sum < (AW+2)'(DEPTH);
  // reset_n gates the request so it is low for the whole reset interval.
  assign mem_rd     = reset_n & ~redirect & ((k_q != 2'd0) | credit);
  assign mem_addr   = fpc_q[MEM_AW-1:0] + MEM_AW'(k_q);
  assign start_word = mem_rd & (k_q == 2'd0);

  assign cap_word     = {asm_q, mem_rdata};
  assign capture_done = rd_pend_q & (c_q == 2'd3) & ~redirect;
  assign fifo_valid   = (count_q != '0);
  assign pop          = fifo_valid & inst_ready & ~redirect;

`ifdef IFETCH_BYPASS_EN
  assign byp_show = capture_done & ~fifo_valid;
  assign byp_take = byp_show & inst_ready;
`else
  assign byp_show = 1'b0;
  assign byp_take = 1'b0;
`endif

  assign push        = capture_done & ~byp_take;
  assign inst_valid  = fifo_valid | byp_show;
  assign dbg_state_o = state_q;

  always_comb begin
    if (fifo_valid) begin
      inst    = fifo_inst[rd_ptr_q];
      inst_pc = fifo_pc[rd_ptr_q];
    end else if (byp_show) begin
      inst    = cap_word;
      inst_pc = cap_pc_q;
    end else begin
      inst    = last_inst_q;
      inst_pc = last_pc_q;
    end
  end

  always_comb begin
    fpc_d    = fpc_q;
    k_d      = k_q;
    c_d      = c_q;
    asm_d    = asm_q;
    cap_pc_d = cap_pc_q;
    wif_d    = wif_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    state_d  = state_q;
    if (redirect) begin
      fpc_d    = {redirect_pc[31:2], 2'b00};
      k_d      = 2'd0;
      c_d      = 2'd0;
      cap_pc_d = {redirect_pc[31:2], 2'b00};
      wif_d    = 2'd0;
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      state_d  = ST_ISSUE;
    end else begin
      if (mem_rd) begin
        if (k_q == 2'd3) begin
          k_d   = 2'd0;
          fpc_d = fpc_q + 32'd4;
        end else begin
          k_d = k_q + 2'd1;
        end
      end
      // WAIT means a word boundary was reached without credit to start one.
      state_d = ((k_q == 2'd0) && !mem_rd) ? ST_WAIT : ST_ISSUE;
      if (rd_pend_q) begin
        c_d = c_q + 2'd1;
        case (c_q)
          2'd0:    asm_d[23:16] = mem_rdata;
          2'd1:    asm_d[15:8]  = mem_rdata;
          2'd2:    asm_d[7:0]   = mem_rdata;
          default: asm_d        = asm_q;
        endcase
      end
      // Words are issued and captured in order, so the capture PC simply
      // advances by one word per completed capture.
      if (capture_done) cap_pc_d = cap_pc_q + 32'd4;
      wif_d   = wif_q + 2'(start_word) - 2'(capture_done);
      count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_ISSUE;
      fpc_q       <= '0;
      k_q         <= '0;
      c_q         <= '0;
      asm_q       <= '0;
      rd_pend_q   <= 1'b0;
      cap_pc_q    <= '0;
      wif_q       <= '0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      last_inst_q <= '0;
      last_pc_q   <= '0;
    end else begin
      state_q   <= state_d;
      fpc_q     <= fpc_d;
      k_q       <= k_d;
      c_q       <= c_d;
      asm_q     <= asm_d;
      rd_pend_q <= mem_rd;
      cap_pc_q  <= cap_pc_d;
      wif_q     <= wif_d;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      if (inst_valid) begin
        last_inst_q <= inst;
        last_pc_q   <= inst_pc;
      end
    end
  end

  // Storage needs no reset: count_q gates every read of it.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_inst[wr_ptr_q] <= cap_word;
      fifo_pc[wr_ptr_q]   <= cap_pc_q;
    end
  end

endmodule
